// File: rtl/sync_clear_pkg.sv
// Shared definitions for the sync_clear_reg block.
// Contents:
//   cnt_width       - width of a down-counter that must hold the value n,
//                     never narrower than one bit
//   CLR_VAL_DEFAULT - default clear value (all zeros); the top slices it to WIDTH
//   EVT_W_DEFAULT   - default width of the clear-event counter
package sync_clear_pkg;

  localparam logic [63:0] CLR_VAL_DEFAULT = '0;
  localparam int          EVT_W_DEFAULT   = 8;

  // A counter that must reach n needs clog2(n+1) bits. A hold length of zero
  // would give a zero-width vector, so the result is floored at one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clr_stretch.sv
// Retriggerable clear-stretch counter.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset; aborts any hold in progress
//   any_clr    - qualified clear request for this cycle
//   clr_active - combinational: request now, or a stretch still counting down
module clr_stretch
  import sync_clear_pkg::*;
#(
  parameter int HOLD_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic any_clr,
  output logic clr_active
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

  logic [CW-1:0] hold_cnt;

  // Every request reloads the full hold length, so a fresh request during a
  // stretch extends it rather than letting it expire early. With HOLD_CYCLES
  // of zero the load value is zero and the counter never leaves zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (any_clr) begin
      hold_cnt <= HOLD_VAL;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // The clear covers the request cycle itself plus every cycle in which the
  // counter is still non-zero.
  assign clr_active = any_clr | (hold_cnt != '0);

endmodule

// File: rtl/sync_clear_reg.sv
// Data register with maskable synchronous clear sources.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   clr_in     - clear requests, active-high, level-sampled
//   clr_mask   - per-source enable, 1 lets the source clear
//   load_en    - capture data_in when no clear is active
//   data_in    - data to register
//   cause_ack  - clears the sticky cause record
//   data_out   - registered data
//   clr_active - combinational clear term, a single net meant for a flop's
//                dedicated synchronous reset pin
//   clr_cause  - sticky record of the sources that caused a clear
//   evt_cnt    - saturating count of clear-request rising edges
module sync_clear_reg
  import sync_clear_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               NUM_CLR     = 3,
  parameter logic [WIDTH-1:0] CLR_VAL     = CLR_VAL_DEFAULT[WIDTH-1:0],
  parameter int               HOLD_CYCLES = 0,
  parameter int               EVT_W       = EVT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CLR-1:0] clr_in,
  input  logic [NUM_CLR-1:0] clr_mask,
  input  logic               load_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               cause_ack,
  output logic [WIDTH-1:0]   data_out,
  output logic               clr_active,
  output logic [NUM_CLR-1:0] clr_cause,
  output logic [EVT_W-1:0]   evt_cnt
);

  logic [NUM_CLR-1:0] clr_req;
  logic               any_clr;
  logic               any_clr_q;

  // Only unmasked sources count as requests anywhere in the block.
  assign clr_req = clr_in & clr_mask;
  assign any_clr = |clr_req;

  clr_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clk       (clk),
    .rst_n     (rst_n),
    .any_clr   (any_clr),
    .clr_active(clr_active)
  );

  // Clear beats load; with neither the register holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= CLR_VAL;
    end else if (clr_active) begin
      data_out <= CLR_VAL;
    end else if (load_en) begin
      data_out <= data_in;
    end
  end

  // The acknowledge wipes the old record, but requesting bits are ORed in
  // afterwards, so a request in the ack cycle is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cause <= '0;
    end else begin
      clr_cause <= (clr_cause & ~{NUM_CLR{cause_ack}}) | clr_req;
    end
  end

  // Count rising edges of the qualified request; a long level counts once.
  // Reset clears the edge-detect history, so a request still asserted after
  // reset release is a new event. The count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_clr_q <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      any_clr_q <= any_clr;
      if (any_clr && !any_clr_q && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_clear_reg.sv
// Scoreboard bench for sync_clear_reg (WIDTH=2, NUM_CLR=3, CLR_VAL=0,
// HOLD_CYCLES=3, EVT_W=2). Each directed vector carries the expected
// clr_active for its own cycle and the register values after its edge.
module tb_sync_clear_reg;

  typedef struct {
    logic       rst_n;
    logic [2:0] clr_in;
    logic [2:0] clr_mask;
    logic       load_en;
    logic [1:0] data_in;
    logic       cause_ack;
    logic       chk_act;
    logic       exp_act;
    logic [1:0] exp_data;
    logic [2:0] exp_cause;
    logic [1:0] exp_evt;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] clr_in;
  logic [2:0] clr_mask;
  logic       load_en;
  logic [1:0] data_in;
  logic       cause_ack;
  logic [1:0] data_out;
  logic       clr_active;
  logic [2:0] clr_cause;
  logic [1:0] evt_cnt;

  vec_t stim_q[$];
  vec_t exp_q[$];
  int   checks;
  int   failures;

  sync_clear_reg #(
    .WIDTH      (2),
    .NUM_CLR    (3),
    .CLR_VAL    (2'b00),
    .HOLD_CYCLES(3),
    .EVT_W      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_in    (clr_in),
    .clr_mask  (clr_mask),
    .load_en   (load_en),
    .data_in   (data_in),
    .cause_ack (cause_ack),
    .data_out  (data_out),
    .clr_active(clr_active),
    .clr_cause (clr_cause),
    .evt_cnt   (evt_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: run did not finish within 100000 time units");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected, input int idx);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=%0h required=%0h", name, idx, actual, expected);
    end
  endtask

  task automatic addVec(input logic r, input logic [2:0] clr, input logic [2:0] mask,
                        input logic ld, input logic [1:0] din, input logic ack,
                        input logic chk, input logic act, input logic [1:0] dat,
                        input logic [2:0] cause, input logic [1:0] evt);
    vec_t v;
    v.rst_n = r;     v.clr_in = clr;   v.clr_mask = mask;
    v.load_en = ld;  v.data_in = din;  v.cause_ack = ack;
    v.chk_act = chk; v.exp_act = act;  v.exp_data = dat;
    v.exp_cause = cause; v.exp_evt = evt;
    stim_q.push_back(v);
  endtask

  // Drive one vector on the falling edge and hand its expectation to the
  // scoreboard.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n     = v.rst_n;
    clr_in    = v.clr_in;
    clr_mask  = v.clr_mask;
    load_en   = v.load_en;
    data_in   = v.data_in;
    cause_ack = v.cause_ack;
    exp_q.push_back(v);
  endtask

  // Monitor: clr_active is sampled mid-cycle once the inputs have settled,
  // the registered outputs just after the following rising edge.
  initial begin
    vec_t e;
    logic act_s;
    int   idx;
    idx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        act_s = clr_active;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.chk_act) checkOutput("clr_active", {7'b0, act_s}, {7'b0, e.exp_act}, idx);
        checkOutput("data_out",  {6'b0, data_out},  {6'b0, e.exp_data},  idx);
        checkOutput("clr_cause", {5'b0, clr_cause}, {5'b0, e.exp_cause}, idx);
        checkOutput("evt_cnt",   {6'b0, evt_cnt},   {6'b0, e.exp_evt},   idx);
        idx++;
      end
    end
  end

  // Directed vectors, expected values worked out by hand for HOLD_CYCLES=3.
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clr_in    = 3'b000;
    clr_mask  = 3'b111;
    load_en   = 1'b0;
    data_in   = 2'b00;
    cause_ack = 1'b0;

    //     rst clr     mask    ld din    ack chk act dat    cause   evt
    // reset state
    addVec(0, 3'b000, 3'b111, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 2'd0);  // 0
    addVec(0, 3'b000, 3'b111, 0, 2'b00, 0, 1, 0, 2'b00, 3'b000, 2'd0);  // 1
    // load, then a one-cycle clear stretched over four edges
    addVec(1, 3'b000, 3'b111, 1, 2'b11, 0, 1, 0, 2'b11, 3'b000, 2'd0);  // 2
    addVec(1, 3'b010, 3'b111, 1, 2'b11, 0, 1, 1, 2'b00, 3'b010, 2'd1);  // 3
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 1, 2'b00, 3'b010, 2'd1);  // 4
    // retrigger on the third forced edge: four more forced edges
    addVec(1, 3'b001, 3'b111, 1, 2'b10, 0, 1, 1, 2'b00, 3'b011, 2'd2);  // 5
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 1, 2'b00, 3'b011, 2'd2);  // 6
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 1, 2'b00, 3'b011, 2'd2);  // 7
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 1, 2'b00, 3'b011, 2'd2);  // 8
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 0, 2'b10, 3'b011, 2'd2);  // 9
    // ack alone, data holds without load
    addVec(1, 3'b000, 3'b111, 0, 2'b01, 1, 1, 0, 2'b10, 3'b000, 2'd2);  // 10
    // cause accumulates 001 then 100; level stays high so one event only
    addVec(1, 3'b001, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 11
    addVec(1, 3'b100, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b101, 2'd3);  // 12
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b101, 2'd3);  // 13
    // ack together with a new request: the request bit survives; count saturated
    addVec(1, 3'b010, 3'b111, 1, 2'b01, 1, 1, 1, 2'b00, 3'b010, 2'd3);  // 14
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b010, 2'd3);  // 15
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b010, 2'd3);  // 16
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b010, 2'd3);  // 17
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 0, 2'b01, 3'b010, 2'd3);  // 18
    // reset clears cause and counter
    addVec(0, 3'b000, 3'b111, 1, 2'b11, 0, 1, 0, 2'b00, 3'b000, 2'd0);  // 19
    // masked-out source held for five cycles has no effect
    addVec(1, 3'b010, 3'b101, 1, 2'b10, 0, 1, 0, 2'b10, 3'b000, 2'd0);  // 20
    addVec(1, 3'b010, 3'b101, 1, 2'b01, 0, 1, 0, 2'b01, 3'b000, 2'd0);  // 21
    addVec(1, 3'b010, 3'b101, 1, 2'b11, 0, 1, 0, 2'b11, 3'b000, 2'd0);  // 22
    addVec(1, 3'b010, 3'b101, 1, 2'b00, 0, 1, 0, 2'b00, 3'b000, 2'd0);  // 23
    addVec(1, 3'b010, 3'b101, 1, 2'b10, 0, 1, 0, 2'b10, 3'b000, 2'd0);  // 24
    // clr_in[0] held for ten cycles counts as one event
    for (int i = 0; i < 10; i++)
      addVec(1, 3'b001, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b001, 2'd1); // 25..34
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b001, 2'd1);  // 35
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b001, 2'd1);  // 36
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 1, 2'b00, 3'b001, 2'd1);  // 37
    addVec(1, 3'b000, 3'b111, 1, 2'b01, 0, 1, 0, 2'b01, 3'b001, 2'd1);  // 38
    // five separate pulses: 1 -> 2 -> 3, then stuck at 3
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd2);  // 39
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd2);  // 40
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 41
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 42
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 43
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 44
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 45
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 46
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 47
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 48
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 49
    addVec(1, 3'b000, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd3);  // 50
    addVec(1, 3'b000, 3'b111, 1, 2'b11, 0, 1, 0, 2'b11, 3'b001, 2'd3);  // 51
    // reset on the second hold cycle aborts the stretch
    addVec(1, 3'b100, 3'b111, 1, 2'b11, 0, 1, 1, 2'b00, 3'b101, 2'd3);  // 52
    addVec(1, 3'b000, 3'b111, 1, 2'b11, 0, 1, 1, 2'b00, 3'b101, 2'd3);  // 53
    addVec(0, 3'b000, 3'b111, 1, 2'b11, 0, 1, 1, 2'b00, 3'b000, 2'd0);  // 54
    addVec(1, 3'b000, 3'b111, 1, 2'b10, 0, 1, 0, 2'b10, 3'b000, 2'd0);  // 55
    // request held through reset release is a new event
    addVec(0, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b000, 2'd0);  // 56
    addVec(1, 3'b001, 3'b111, 0, 2'b00, 0, 1, 1, 2'b00, 3'b001, 2'd1);  // 57

    while (stim_q.size() > 0) applyStimulus(stim_q.pop_front());

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", 8'(exp_q.size()), 8'd0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_clear_reg.md
# sync_clear_reg

Parametrised data register with multiple maskable synchronous clear sources, a programmable clear-stretch counter, sticky clear-cause capture and a saturating clear-event counter. It is the general successor to the team's fixed two-bit, three-input synchronous-clear register examples. It sits directly in front of downstream datapath flops that need a dedicated, attribute-friendly clear. The final clear term is a single net, `clr_active`, suitable for mapping onto a flop's dedicated synchronous reset pin.

## Interface
Parameters:
- `WIDTH`, 2: data width, ≥1
- `NUM_CLR`, 3: number of clear sources, ≥1
- `CLR_VAL`, all zeros: value forced onto `data_out` while a clear is active, WIDTH bits
- `HOLD_CYCLES`, 0: extra cycles the clear is stretched after the last qualifying request, ≥0
- `EVT_W`, 8: width of the clear-event counter, ≥1

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clr_in`  in  NUM_CLR  clear requests, active-high, level-sampled
- `clr_mask`  in  NUM_CLR  per-source enable; 1 means the source is allowed to clear
- `load_en`  in  1  capture `data_in` when no clear is active
- `data_in`  in  WIDTH  data to register
- `cause_ack`  in  1  clears `clr_cause`
- `data_out`  out  WIDTH  registered data
- `clr_active`  out  1  combinational; high while `data_out` is being forced to `CLR_VAL` at the next edge
- `clr_cause`  out  NUM_CLR  sticky record of which sources caused a clear
- `evt_cnt`  out  EVT_W  saturating count of clear-request rising edges

## Operation
Clear qualification:
- `any_clr = |(clr_in & clr_mask)`.
- `clr_active = any_clr | (hold_cnt != 0)`.

Per-edge priority, highest first:
1. `rst_n == 0`:
   - `data_out` ← `CLR_VAL`
   - `hold_cnt` ← 0
   - `clr_cause` ← 0
   - `evt_cnt` ← 0
   - `any_clr_q` ← 0
2. `clr_active`: `data_out` ← `CLR_VAL`.
3. `load_en`: `data_out` ← `data_in`.
4. Otherwise `data_out` holds its value.

Stretch counter `hold_cnt`:
- Width is `max(1, clog2(HOLD_CYCLES+1))`.
- `any_clr` loads `HOLD_CYCLES`.
- Otherwise it decrements when non-zero.
- A new request while counting reloads the counter; the hold is retriggerable.

Cause register:
- `clr_cause` ← `(clr_cause & ~{NUM_CLR{cause_ack}}) | (clr_in & clr_mask)`.
- If `cause_ack` and a new request occur in the same cycle, the set wins for the requesting bits.

Event counter:
- Increments when `any_clr & ~any_clr_q`, where `any_clr_q` is `any_clr` registered.
- Saturates at all-ones; it never wraps.

Masked-out sources have no effect on `data_out`, `clr_cause` or `evt_cnt`.

## Timing
- `data_out` latency is one edge in both cases:
  - A load in cycle t is visible after edge t.
  - A clear in cycle t forces `CLR_VAL` after edge t.
- A single-cycle request at cycle t forces `CLR_VAL` for edges t … t+HOLD_CYCLES, i.e. 1+HOLD_CYCLES edges. The first edge that can load is t+HOLD_CYCLES+1.
- `clr_active` goes high combinationally in the cycle `any_clr` rises. It falls in the cycle after `hold_cnt` reaches 0 with no request pending.
- `clr_cause` and `evt_cnt` update one edge after the qualifying cycle.
- Reset:
  - If `rst_n` is low mid-hold, the hold is aborted: `hold_cnt` = 0 after that edge.
  - If `clr_in` is still asserted on the first cycle after reset, it is treated as a new event and `evt_cnt` increments.
- With `HOLD_CYCLES = 0` the block reduces to a plain OR-clear register and `hold_cnt` is constant 0.

## Structure
- Package `sync_clear_pkg`:
  - `clog2`-based width helper function
  - default-value localparams for `CLR_VAL_DEFAULT` and `EVT_W_DEFAULT`
- Sub-module `clr_stretch`:
  - parameters: `HOLD_CYCLES`
  - inputs: `clk`, `rst_n`, `any_clr`
  - output: `clr_active`
  - contains the retriggerable down-counter
- The top level holds:
  - the data register
  - cause logic
  - event counter
  - edge detect

## Test plan
Defaults are `WIDTH=2`, `NUM_CLR=3` and `CLR_VAL=0` unless a scenario says otherwise.
- Basic load/clear (`HOLD_CYCLES=0`, mask `3'b111`):
  - `load_en=1`, `data_in=2'b11` → `data_out=2'b11` next edge.
  - Pulse `clr_in=3'b010` for 1 cycle → `data_out=2'b00` for exactly 1 edge, then 2'b11 reloads.
- Stretch (`HOLD_CYCLES=3`): 1-cycle pulse on `clr_in[0]` with `load_en` held high and `data_in=2'b10` → `data_out=0` for 4 edges, 2'b10 on the 5th. A second pulse on the 3rd hold edge → 4 more forced edges from that point.
- Mask: `clr_mask=3'b101`, `clr_in=3'b010` for 5 cycles → `data_out` keeps loading `data_in`; `clr_cause=0` and `evt_cnt=0` throughout.
- Cause/ack:
  - Pulse `clr_in=3'b001`, then `clr_in=3'b100` → `clr_cause=3'b101`.
  - `cause_ack` alone → 3'b000.
  - `cause_ack` with `clr_in=3'b010` in the same cycle → 3'b010.
- Event count (`EVT_W=2`):
  - Hold `clr_in[0]` high for 10 cycles → `evt_cnt=1`.
  - 5 separate pulses → saturates at 3 and stays there.
- Reset mid-hold (`HOLD_CYCLES=7`): assert `rst_n=0` on hold cycle 2 for 1 cycle → all outputs 0. The first load edge after release with no request pending → `data_out=data_in`.
